// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC sequencing, redirects, fetch register, halt on out-of-range PC
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic [31:0] imem_inst,
  output logic [31:0] imem_addr,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] NOP      = 32'h0000_0000;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_inst_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc4_q;
  logic        if_valid_q;
  logic        halted_q;

  logic        redirect;
  logic [31:0] redir_pc;
  logic [31:0] pc_plus4;
  logic        pc_oob;

  // Jump wins over branch; targets are word-aligned by clearing the low two bits.
  assign redirect = jmp | br_taken;
  assign redir_pc = (jmp ? jmp_target : br_target) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_oob   = (pc_q >= PC_LIMIT);

  // Fetch FSM: START is a single idle cycle, RUN fetches, HALT parks until a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= START;
      pc_q       <= RESET_PC;
      if_inst_q  <= NOP;
      if_pc_q    <= 32'h0000_0000;
      if_pc4_q   <= 32'h0000_0000;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          state_q <= RUN;
        end
        RUN: begin
          if (redirect) begin
            // Redirect overrides stall; if_pc/if_pc4 keep the last real fetch.
            pc_q       <= redir_pc;
            if_inst_q  <= NOP;
            if_valid_q <= 1'b0;
          end else if (!stall) begin
            if (pc_oob) begin
              if_inst_q  <= NOP;
              if_valid_q <= 1'b0;
              halted_q   <= 1'b1;
              state_q    <= HALT;
            end else begin
              if_inst_q  <= imem_inst;
              if_pc_q    <= pc_q;
              if_pc4_q   <= pc_plus4;
              if_valid_q <= 1'b1;
              pc_q       <= pc_plus4;
            end
          end
        end
        HALT: begin
          if (redirect) begin
            pc_q       <= redir_pc;
            if_inst_q  <= NOP;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            state_q    <= RUN;
          end
        end
        default: begin
          state_q  <= START;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc4_q;
  assign if_valid  = if_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_target = 32'h0;
  logic [31:0] imem_inst;
  logic [31:0] imem_addr;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;

  logic [31:0] mem [0:31];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_t;
    logic        jmp;
    logic [31:0] jmp_t;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_ifpc;
    logic [31:0] e_ifpc4;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vq[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .jmp(jmp),
    .jmp_target(jmp_target),
    .imem_inst(imem_inst),
    .imem_addr(imem_addr),
    .if_inst(if_inst),
    .if_pc(if_pc),
    .if_pc4(if_pc4),
    .if_valid(if_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_addr[6:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h required %08h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] ifpc, input logic [31:0] ifpc4,
                           input logic valid, input logic hlt);
    check({tag, ".pc"},     imem_addr, pc);
    check({tag, ".inst"},   if_inst, inst);
    check({tag, ".if_pc"},  if_pc, ifpc);
    check({tag, ".if_pc4"}, if_pc4, ifpc4);
    check({tag, ".valid"},  {31'b0, if_valid}, {31'b0, valid});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, hlt});
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt,
                     input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] ifpc, input logic [31:0] ifpc4,
                     input logic valid, input logic hlt);
    vec_t v;
    v.stall = s; v.br = b; v.br_t = bt; v.jmp = j; v.jmp_t = jt;
    v.e_pc = pc; v.e_inst = inst; v.e_ifpc = ifpc; v.e_ifpc4 = ifpc4;
    v.e_valid = valid; v.e_halted = hlt;
    vq.push_back(v);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    stall = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h3c01_1234;
    mem[1] = 32'h3421_5678;

    //    stall br  br_t          jmp jmp_t         pc            inst          if_pc         if_pc4        v     h
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h00, 32'h0,         32'h00, 32'h00, 1'b0, 1'b0); // START
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h04, 32'h3c01_1234, 32'h00, 32'h04, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h3421_5678, 32'h04, 32'h08, 1'b1, 1'b0);
    add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h3421_5678, 32'h04, 32'h08, 1'b1, 1'b0); // stall x3
    add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h3421_5678, 32'h04, 32'h08, 1'b1, 1'b0);
    add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h3421_5678, 32'h04, 32'h08, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 32'hA000_0002, 32'h08, 32'h0C, 1'b1, 1'b0);
    add(1'b1, 1'b1, 32'h13, 1'b0, 32'h0,  32'h10, 32'h0,         32'h08, 32'h0C, 1'b0, 1'b0); // br over stall
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h14, 32'hA000_0004, 32'h10, 32'h14, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h20, 1'b1, 32'h40, 32'h40, 32'h0,         32'h10, 32'h14, 1'b0, 1'b0); // jmp > br
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h44, 32'hA000_0010, 32'h40, 32'h44, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b1, 32'h7B, 32'h78, 32'h0,         32'h40, 32'h44, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h7C, 32'hA000_001E, 32'h78, 32'h7C, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80, 32'hA000_001F, 32'h7C, 32'h80, 1'b1, 1'b0); // last word
    add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80, 32'hA000_001F, 32'h7C, 32'h80, 1'b1, 1'b0); // stalled oob
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80, 32'h0,         32'h7C, 32'h80, 1'b0, 1'b1); // halt
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80, 32'h0,         32'h7C, 32'h80, 1'b0, 1'b1);
    add(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80, 32'h0,         32'h7C, 32'h80, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h00, 32'h0,         32'h7C, 32'h80, 1'b0, 1'b0); // leave halt
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h04, 32'h3c01_1234, 32'h00, 32'h04, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h200,1'b0, 32'h0,  32'h200,32'h0,         32'h00, 32'h04, 1'b0, 1'b0); // oob target
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h200,32'h0,         32'h00, 32'h04, 1'b0, 1'b1);
    add(1'b1, 1'b1, 32'h0C, 1'b0, 32'h0,  32'h0C, 32'h0,         32'h00, 32'h04, 1'b0, 1'b0); // br leaves halt
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 32'hA000_0003, 32'h0C, 32'h10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 32'h80, 32'h0,         32'h0C, 32'h10, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80, 32'h0,         32'h0C, 32'h10, 1'b0, 1'b1); // halted again

    // Asynchronous reset with no clock edge.
    #1 rst = 1'b1;
    #1 check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].stall, vq[i].br, vq[i].br_t, vq[i].jmp, vq[i].jmp_t);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_inst, vq[i].e_ifpc,
                vq[i].e_ifpc4, vq[i].e_valid, vq[i].e_halted);
    end

    // Reset pulsed between edges while halted; inputs ignored while held.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h24, 1'b1, 32'h40);
    #1 check_all("halt_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_all("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1 check_all("post_start", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_all("post_f0", 32'h4, 32'h3c01_1234, 32'h0, 32'h4, 1'b1, 1'b0);
    @(posedge clk);
    #1 check_all("post_f1", 32'h8, 32'h3421_5678, 32'h4, 32'h8, 1'b1, 1'b0);

    // Reset asserted mid-stall.
    stall = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all("stall_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
